// File: rtl/vz_loader.sv
// rtl/vz_loader.sv - VZ image download sequencer feeding the Laser310 system RAM port
module vz_loader #(
  parameter logic [7:0]  VZ_INDEX      = 8'd1,
  parameter int          FIFO_DEPTH    = 4,
  parameter logic [15:0] BASIC_END_PTR = 16'h78F9
) (
  input  logic        CLK10MHZ,
  input  logic        RESET,
  input  logic        dn_download,
  input  logic [7:0]  dn_index,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic        dn_wr,
  output logic        cpu_hold,
  input  logic        cpu_held,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  input  logic        mem_ack,
  output logic        exec_valid,
  output logic [15:0] exec_addr,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  localparam logic [7:0] TYPE_BASIC = 8'hF0;
  localparam logic [7:0] TYPE_BIN   = 8'hF1;

  localparam logic [2:0] ERR_SHORT = 3'd1;
  localparam logic [2:0] ERR_TYPE  = 3'd2;
  localparam logic [2:0] ERR_OVF   = 3'd3;
  localparam logic [2:0] ERR_WRAP  = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_DRAIN,
    S_PTR_LO,
    S_PTR_HI,
    S_DONE,
    S_EXEC,
    S_ERROR
  } state_t;

  state_t state, state_n;

  logic          sel_q;
  logic          dl_q;
  logic [7:0]    type_q;
  logic [15:0]   start_q;
  logic [15:0]   len_q;

  logic [15:0]   fifo_addr [FIFO_DEPTH];
  logic [7:0]    fifo_data [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          mem_req_q;
  logic [15:0]   mem_addr_q;
  logic [7:0]    mem_data_q;
  logic          done_q;
  logic [2:0]    err_q;

  logic          sel;
  logic          rise;
  logic          accept;
  logic          is_payload;
  logic [15:0]   offset;
  logic [16:0]   target;
  logic          wrap;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          type_ok;
  logic [15:0]   end_addr;

  logic          push;
  logic          clear_load;
  logic          flush;
  logic          len_inc;
  logic          err_set;
  logic [2:0]    err_code;

  // A byte strobed in the very cycle dn_download drops still belongs to the image,
  // so acceptance also looks at the previous cycle's download level.
  assign sel        = dn_download && (dn_index == VZ_INDEX);
  assign rise       = sel && !sel_q;
  assign accept     = dn_wr && (dn_index == VZ_INDEX) && (dn_download || dl_q);
  assign is_payload = accept && (dn_addr >= 16'd24);
  assign offset     = dn_addr - 16'd24;
  assign target     = {1'b0, start_q} + {1'b0, offset};
  assign wrap       = target[16];
  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign pop        = mem_req_q && mem_ack && ((state == S_DATA) || (state == S_DRAIN));
  assign type_ok    = (type_q == TYPE_BASIC) || (type_q == TYPE_BIN);
  assign end_addr   = start_q + len_q;

  assign cpu_hold   = (state == S_DATA) || (state == S_DRAIN) ||
                      (state == S_PTR_LO) || (state == S_PTR_HI);
  assign busy       = cpu_hold || (state == S_HEADER);
  assign exec_valid = (state == S_EXEC);
  assign exec_addr  = exec_valid ? start_q : 16'h0000;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign done       = done_q;
  assign err        = err_q;

  // State register and download edge trackers.
  always_ff @(posedge CLK10MHZ) begin
    if (!RESET) begin
      state <= S_IDLE;
      sel_q <= 1'b0;
      dl_q  <= 1'b0;
    end else begin
      state <= state_n;
      sel_q <= sel;
      dl_q  <= dn_download;
    end
  end

  // Next-state decode plus the per-cycle push / error / clear controls.
  always_comb begin
    state_n    = state;
    push       = 1'b0;
    clear_load = 1'b0;
    flush      = 1'b0;
    len_inc    = 1'b0;
    err_set    = 1'b0;
    err_code   = 3'd0;
    case (state)
      S_IDLE: begin
        if (rise) begin
          clear_load = 1'b1;
          state_n    = S_HEADER;
        end
      end
      S_HEADER: begin
        if (accept && (dn_addr == 16'd23)) begin
          if (type_ok) begin
            state_n = S_DATA;
          end else begin
            err_set  = 1'b1;
            err_code = ERR_TYPE;
            state_n  = S_ERROR;
          end
        end else if (!dn_download) begin
          err_set  = 1'b1;
          err_code = ERR_SHORT;
          state_n  = S_ERROR;
        end
      end
      S_DATA: begin
        if (!dn_download) begin
          state_n = S_DRAIN;
        end
        if (is_payload) begin
          len_inc = 1'b1;
          if (wrap) begin
            // Bytes past the top of memory are dropped but the load carries on.
            err_set  = 1'b1;
            err_code = ERR_WRAP;
          end else if (fifo_full && !pop) begin
            err_set  = 1'b1;
            err_code = ERR_OVF;
            state_n  = S_ERROR;
          end else begin
            push = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          state_n = (type_q == TYPE_BASIC) ? S_PTR_LO : S_DONE;
        end
      end
      S_PTR_LO: begin
        if (mem_req_q && mem_ack) begin
          state_n = S_PTR_HI;
        end
      end
      S_PTR_HI: begin
        if (mem_req_q && mem_ack) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = (type_q == TYPE_BIN) ? S_EXEC : S_IDLE;
      end
      S_EXEC: begin
        state_n = S_IDLE;
      end
      S_ERROR: begin
        flush = 1'b1;
        if (!dn_download) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Header fields and payload length for the end-pointer patch.
  always_ff @(posedge CLK10MHZ) begin
    if (!RESET) begin
      type_q  <= 8'h00;
      start_q <= 16'h0000;
      len_q   <= 16'h0000;
    end else begin
      if (clear_load) begin
        type_q  <= 8'h00;
        start_q <= 16'h0000;
        len_q   <= 16'h0000;
      end
      if ((state == S_HEADER) && accept) begin
        case (dn_addr)
          16'd21:  type_q        <= dn_data;
          16'd22:  start_q[7:0]  <= dn_data;
          16'd23:  start_q[15:8] <= dn_data;
          default: ;
        endcase
      end
      if (len_inc) begin
        len_q <= len_q + 16'd1;
      end
    end
  end

  // Payload FIFO pointers and occupancy.
  always_ff @(posedge CLK10MHZ) begin
    if (!RESET || clear_load || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload FIFO storage: absolute RAM address and data per entry.
  always_ff @(posedge CLK10MHZ) begin
    if (push) begin
      fifo_addr[wr_ptr] <= target[15:0];
      fifo_data[wr_ptr] <= dn_data;
    end
  end

  // RAM write port: one request at a time, held stable until acknowledged.
  always_ff @(posedge CLK10MHZ) begin
    if (!RESET) begin
      mem_req_q  <= 1'b0;
      mem_addr_q <= 16'h0000;
      mem_data_q <= 8'h00;
    end else if ((state == S_ERROR) || (state_n == S_ERROR)) begin
      mem_req_q <= 1'b0;
    end else if (mem_req_q) begin
      if (mem_ack) begin
        mem_req_q <= 1'b0;
      end
    end else if (cpu_held) begin
      if (((state == S_DATA) || (state == S_DRAIN)) && !fifo_empty) begin
        mem_req_q  <= 1'b1;
        mem_addr_q <= fifo_addr[rd_ptr];
        mem_data_q <= fifo_data[rd_ptr];
      end else if (state == S_PTR_LO) begin
        mem_req_q  <= 1'b1;
        mem_addr_q <= BASIC_END_PTR;
        mem_data_q <= end_addr[7:0];
      end else if (state == S_PTR_HI) begin
        mem_req_q  <= 1'b1;
        mem_addr_q <= BASIC_END_PTR + 16'd1;
        mem_data_q <= end_addr[15:8];
      end
    end
  end

  // Sticky completion and error status, cleared when a new load begins.
  always_ff @(posedge CLK10MHZ) begin
    if (!RESET) begin
      done_q <= 1'b0;
      err_q  <= 3'd0;
    end else if (clear_load) begin
      done_q <= 1'b0;
      err_q  <= 3'd0;
    end else begin
      if (err_set) begin
        err_q <= err_code;
      end
      if ((state == S_DONE) && (err_q == 3'd0)) begin
        done_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vz_loader.sv
// tb/tb_vz_loader.sv - randomized self-checking bench for vz_loader against a file-level model
module tb_vz_loader;

  logic        clk;
  logic        resetn;
  logic        dn_download;
  logic [7:0]  dn_index;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        cpu_hold;
  logic        cpu_held;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ack;
  logic        exec_valid;
  logic [15:0] exec_addr;
  logic        busy;
  logic        done;
  logic [2:0]  err;

  int n_chk;
  int n_bad;

  logic        tie_held;
  int          held_delay;
  int          hold_cnt;

  logic [15:0] got_a[$];
  logic [7:0]  got_d[$];
  int          exec_cnt;
  logic [15:0] exec_got;
  int          exec_wide;
  int          held_viol;
  int          unstable;
  int          bh_viol;
  int          hold_cyc;
  int          busy_cyc;
  logic        exec_prev;
  logic        req_prev;
  logic        held_prev;
  logic [15:0] addr_prev;
  logic [7:0]  data_prev;

  logic [7:0]  pay [0:255];
  logic [15:0] exp_a[$];
  logic [7:0]  exp_d[$];
  logic [2:0]  prev_err;
  logic        prev_done;

  vz_loader #(
    .VZ_INDEX(8'd1),
    .FIFO_DEPTH(4),
    .BASIC_END_PTR(16'h78F9)
  ) dut (
    .CLK10MHZ(clk),
    .RESET(resetn),
    .dn_download(dn_download),
    .dn_index(dn_index),
    .dn_addr(dn_addr),
    .dn_data(dn_data),
    .dn_wr(dn_wr),
    .cpu_hold(cpu_hold),
    .cpu_held(cpu_held),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_ack(mem_ack),
    .exec_valid(exec_valid),
    .exec_addr(exec_addr),
    .busy(busy),
    .done(done),
    .err(err)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Z80 bus grant: tied high, or follows cpu_hold after a programmable delay
  always @(posedge clk) begin
    #1;
    if (cpu_hold) hold_cnt = hold_cnt + 1;
    else hold_cnt = 0;
    cpu_held = tie_held || (cpu_hold && (hold_cnt > held_delay));
  end

  // RAM acknowledges every request in the cycle after it appears
  always @(posedge clk) begin
    #1;
    mem_ack = mem_req && !mem_ack;
  end

  // Observe writes, exec pulses and handshake rules away from the clock edge
  always @(negedge clk) begin
    if (mem_req && mem_ack) begin
      got_a.push_back(mem_addr);
      got_d.push_back(mem_data);
    end
    if (exec_valid) begin
      exec_cnt = exec_cnt + 1;
      exec_got = exec_addr;
      if (exec_prev) exec_wide = exec_wide + 1;
    end
    if (mem_req && !req_prev && !held_prev) held_viol = held_viol + 1;
    if (mem_req && req_prev && ((mem_addr != addr_prev) || (mem_data != data_prev)))
      unstable = unstable + 1;
    if (cpu_hold && !busy) bh_viol = bh_viol + 1;
    if (cpu_hold) hold_cyc = hold_cyc + 1;
    if (busy) busy_cyc = busy_cyc + 1;
    exec_prev = exec_valid;
    req_prev  = mem_req;
    held_prev = cpu_held;
    addr_prev = mem_addr;
    data_prev = mem_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [15:0] a, input logic [7:0] d, input int gap, input bit drop);
    dn_addr = a;
    dn_data = d;
    dn_wr   = 1'b1;
    if (drop) dn_download = 1'b0;
    tick();
    dn_wr = 1'b0;
    repeat (gap) tick();
  endtask

  function automatic logic [7:0] file_byte(input int i, input logic [7:0] typ, input logic [15:0] start);
    if (i == 21) return typ;
    if (i == 22) return start[7:0];
    if (i == 23) return start[15:8];
    if (i >= 24) return pay[i-24];
    return 8'($urandom);
  endfunction

  // Expected outcome of one download, derived from the file contents alone
  task automatic run_load(input string nm, input logic [7:0] typ, input logic [15:0] start,
                          input int len, input int hdr_len, input int gap, input bit coinc,
                          input bit tie, input int delay, input logic [7:0] idx);
    int base_w, base_e, base_wide, base_viol, base_unst, base_bh, base_hold, base_busy;
    int total, wcnt;
    logic [2:0]  e_err;
    logic        e_done, e_hold, e_exec, wrapped, stalled;
    logic [15:0] e_end;
    tie_held   = tie;
    held_delay = delay;
    base_w = got_a.size();  base_e = exec_cnt;  base_wide = exec_wide;
    base_viol = held_viol;  base_unst = unstable; base_bh = bh_viol;
    base_hold = hold_cyc;   base_busy = busy_cyc;

    dn_index    = idx;
    dn_download = 1'b1;
    tick();
    tick();
    total = (hdr_len >= 0) ? hdr_len : 24 + len;
    for (int i = 0; i < total; i++)
      send_byte(16'(i), file_byte(i, typ, start), gap, coinc && (i == total - 1));
    dn_download = 1'b0;
    for (int k = 0; k < 3000 && (busy || cpu_hold); k++) tick();
    repeat (4) tick();

    exp_a.delete();
    exp_d.delete();
    stalled = !tie && (delay > len * (gap + 1) + 2);
    e_hold = 1'b0; e_exec = 1'b0;
    if (idx != 8'd1) begin
      e_err = prev_err; e_done = prev_done;
    end else if (hdr_len >= 0 && hdr_len < 24) begin
      e_err = 3'd1; e_done = 1'b0;
    end else if (typ != 8'hF0 && typ != 8'hF1) begin
      e_err = 3'd2; e_done = 1'b0;
    end else if (stalled && len > 4) begin
      e_err = 3'd3; e_done = 1'b0; e_hold = 1'b1;
    end else begin
      wrapped = 1'b0;
      for (int i = 0; i < len; i++) begin
        if (int'(start) + i > 65535) wrapped = 1'b1;
        else begin
          exp_a.push_back(16'(int'(start) + i));
          exp_d.push_back(pay[i]);
        end
      end
      if (typ == 8'hF0) begin
        e_end = 16'(int'(start) + len);
        exp_a.push_back(16'h78F9); exp_d.push_back(e_end[7:0]);
        exp_a.push_back(16'h78FA); exp_d.push_back(e_end[15:8]);
      end
      e_err  = wrapped ? 3'd4 : 3'd0;
      e_done = !wrapped;
      e_hold = 1'b1;
      e_exec = (typ == 8'hF1);
    end
    prev_err  = e_err;
    prev_done = e_done;

    wcnt = got_a.size() - base_w;
    chk({nm, " nwrites"}, wcnt, exp_a.size());
    for (int j = 0; j < wcnt && j < exp_a.size(); j++) begin
      chk({nm, " waddr"}, got_a[base_w + j], exp_a[j]);
      chk({nm, " wdata"}, got_d[base_w + j], exp_d[j]);
    end
    chk({nm, " err"}, err, e_err);
    chk({nm, " done"}, done, e_done);
    chk({nm, " exec_cnt"}, exec_cnt - base_e, e_exec ? 1 : 0);
    if (e_exec) chk({nm, " exec_addr"}, exec_got, start);
    chk({nm, " hold_seen"}, (hold_cyc - base_hold) > 0, e_hold);
    chk({nm, " busy_seen"}, (busy_cyc - base_busy) > 0, idx == 8'd1);
    chk({nm, " req_before_held"}, held_viol - base_viol, 0);
    chk({nm, " req_unstable"}, unstable - base_unst, 0);
    chk({nm, " hold_without_busy"}, bh_viol - base_bh, 0);
    chk({nm, " exec_wide"}, exec_wide - base_wide, 0);
    chk({nm, " end_hold"}, cpu_hold, 0);
    chk({nm, " end_busy"}, busy, 0);
  endtask

  initial begin
    logic seen;
    n_chk = 0; n_bad = 0;
    tie_held = 1'b1; held_delay = 0; hold_cnt = 0; cpu_held = 1'b0;
    mem_ack = 1'b0;
    exec_cnt = 0; exec_got = '0; exec_wide = 0; held_viol = 0; unstable = 0;
    bh_viol = 0; hold_cyc = 0; busy_cyc = 0;
    exec_prev = 1'b0; req_prev = 1'b0; held_prev = 1'b0; addr_prev = '0; data_prev = '0;
    prev_err = 3'd0; prev_done = 1'b0;
    resetn = 1'b0; dn_download = 1'b0; dn_index = 8'd0; dn_addr = '0; dn_data = '0; dn_wr = 1'b0;
    repeat (3) tick();
    chk("rst mem_req", mem_req, 0);
    chk("rst cpu_hold", cpu_hold, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst exec_valid", exec_valid, 0);
    chk("rst mem_addr", mem_addr, 0);
    resetn = 1'b1;
    tick();

    pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
    run_load("f1_basic", 8'hF1, 16'h8000, 3, -1, 1, 1'b0, 1'b1, 0, 8'd1);
    run_load("other_idx", 8'hF1, 16'h4000, 3, -1, 1, 1'b0, 1'b1, 0, 8'd2);

    pay[0] = 8'h3C; pay[1] = 8'hC3;
    run_load("f0_ptr", 8'hF0, 16'h7AE9, 2, -1, 1, 1'b1, 1'b1, 0, 8'd1);

    for (int i = 0; i < 5; i++) pay[i] = 8'(8'h10 + i);
    run_load("held_late", 8'hF1, 16'h6000, 4, -1, 0, 1'b0, 1'b0, 20, 8'd1);
    run_load("overflow", 8'hF1, 16'h6000, 5, -1, 0, 1'b0, 1'b0, 20, 8'd1);

    run_load("short_hdr", 8'hF1, 16'h8000, 0, 10, 1, 1'b0, 1'b1, 0, 8'd1);
    run_load("bad_type", 8'h55, 16'h8000, 2, -1, 1, 1'b0, 1'b1, 0, 8'd1);
    run_load("addr_wrap", 8'hF1, 16'hFFFE, 4, -1, 1, 1'b0, 1'b1, 0, 8'd1);

    for (int r = 0; r < 10; r++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
      run_load("rand", ($urandom_range(0, 1) != 0) ? 8'hF1 : 8'hF0, 16'($urandom), len, -1,
               $urandom_range(2, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), 8'd1);
    end

    // Reset in the middle of a RAM write on a fresh load
    tie_held = 1'b1;
    dn_index = 8'd1;
    dn_download = 1'b1;
    tick();
    tick();
    pay[0] = 8'h5A;
    for (int i = 0; i < 25; i++) send_byte(16'(i), file_byte(i, 8'hF1, 16'h9000), 0, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (mem_req) seen = 1'b1;
      else tick();
    end
    chk("rst_mid req_seen", seen, 1);
    resetn = 1'b0;
    dn_download = 1'b0;
    tick();
    chk("rst_mid mem_req", mem_req, 0);
    chk("rst_mid cpu_hold", cpu_hold, 0);
    chk("rst_mid busy", busy, 0);
    resetn = 1'b1;
    prev_err = 3'd0;
    prev_done = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) pay[i] = 8'(8'hE0 + i);
    run_load("after_rst", 8'hF0, 16'h7000, 3, -1, 1, 1'b0, 1'b1, 0, 8'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
